// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle controller sequencing the shared ALU over an 8x16 register file
module alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    input  logic [WIDTH-1:0] instr_imm,
    output logic [WIDTH-1:0] alu_r2,
    output logic [WIDTH-1:0] alu_r3,
    output logic [3:0]       alu_m,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_insta,
    input  logic [WIDTH-1:0] alu_r1,
    input  logic [3:0]       alu_flags,
    output logic             done,
    output logic             illegal,
    output logic [3:0]       flags,
    output logic [15:0]      retired,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t           state;
    logic [15:0]      ir;
    logic [WIDTH-1:0] imm_r;
    logic [WIDTH-1:0] res_h;
    logic [3:0]       flags_h;
    logic [WIDTH-1:0] rf [NREG];

    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       is_reserved;
    logic       is_shift;
    logic       writes_rd;
    logic       loads_flags;

    assign op          = ir[15:12];
    assign rd          = ir[11:9];
    assign rs1         = ir[8:6];
    assign rs2         = ir[5:3];
    assign is_reserved = (op > 4'd10);
    assign is_shift    = (op == 4'd6) || (op == 4'd7) || (op == 4'd8);
    assign writes_rd   = (op <= 4'd9);
    assign loads_flags = (op <= 4'd8) || (op == 4'd10);

    assign dbg_data = rf[dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ir          <= '0;
            imm_r       <= '0;
            res_h       <= '0;
            flags_h     <= '0;
            alu_r2      <= '0;
            alu_r3      <= '0;
            alu_m       <= '0;
            alu_op      <= '0;
            alu_insta   <= '0;
            instr_ready <= 1'b1;
            done        <= 1'b0;
            illegal     <= 1'b0;
            flags       <= '0;
            retired     <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir          <= instr;
                        imm_r       <= instr_imm;
                        instr_ready <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    // Reserved ops skip the ALU entirely and retire one cycle early.
                    if (is_reserved) begin
                        done    <= 1'b1;
                        illegal <= 1'b1;
                        state   <= WB;
                    end else begin
                        alu_r2    <= rf[rs1];
                        alu_r3    <= rf[rs2];
                        alu_op    <= op;
                        alu_insta <= imm_r;
                        alu_m     <= is_shift ? ir[3:0] : 4'd0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    res_h   <= alu_r1;
                    flags_h <= alu_flags;
                    done    <= 1'b1;
                    state   <= WB;
                end
                WB: begin
                    if (writes_rd) begin
                        rf[rd] <= res_h;
                    end
                    if (loads_flags) begin
                        flags <= flags_h;
                    end
                    retired     <= retired + 16'd1;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with an ALU model and scoreboard
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_imm;
    logic [15:0] alu_r2, alu_r3, alu_insta, alu_r1;
    logic [3:0]  alu_m, alu_op, alu_flags;
    logic        done, illegal;
    logic [3:0]  flags;
    logic [15:0] retired;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(16), .NREG(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_imm(instr_imm),
        .alu_r2(alu_r2), .alu_r3(alu_r3), .alu_m(alu_m), .alu_op(alu_op),
        .alu_insta(alu_insta), .alu_r1(alu_r1), .alu_flags(alu_flags),
        .done(done), .illegal(illegal), .flags(flags), .retired(retired),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Reference ALU: flags are {zero, negative, parity, a<b}.
    function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] m,
                                           input logic [15:0] imm);
        logic [15:0] r;
        logic [31:0] rr;
        logic [31:0] prod;
        rr   = {a, a} >> m;
        prod = a * b;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = prod[15:0];
            4'd3:    r = a | b;
            4'd4:    r = a & b;
            4'd5:    r = a ^ b;
            4'd6:    r = a >> m;
            4'd7:    r = a << m;
            4'd8:    r = rr[15:0];
            4'd9:    r = imm;
            4'd10:   r = a - b;
            default: r = 16'h0;
        endcase
        return {(r == 16'h0), r[15], ^r, (a < b), r};
    endfunction

    assign {alu_flags, alu_r1} = alu_fn(alu_op, alu_r2, alu_r3, alu_m, alu_insta);

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [3:0]  m;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_rf [8];
    logic [3:0]  m_flags;
    logic [15:0] m_ret;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check(tag, dbg_data, m_rf[i]);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        m_flags = 4'h0;
        m_ret   = 16'h0;
        sb.delete();
    endtask

    // Drive at a negedge; push the expectation; the accept happens on the next posedge.
    task automatic offer(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [3:0] m, input logic [15:0] imm);
        logic [15:0] w;
        logic [19:0] o;
        exp_t        e;
        w = {op, rd, rs1, rs2, 3'b000} | {12'h0, m};
        instr       = w;
        instr_imm   = imm;
        instr_valid = 1'b1;
        e.op  = op;
        e.a   = m_rf[rs1];
        e.m   = (op == 4'd6 || op == 4'd7 || op == 4'd8) ? m : 4'd0;
        e.ill = (op > 4'd10);
        o = alu_fn(op, m_rf[rs1], m_rf[w[5:3]], e.m, imm);
        sb.push_back(e);
        if (op <= 4'd9) m_rf[rd] = o[15:0];
        if (op <= 4'd8 || op == 4'd10) m_flags = o[19:16];
        m_ret = m_ret + 16'd1;
    endtask

    task automatic run(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [3:0] m, input logic [15:0] imm);
        exp_t e;
        bit   seen;
        for (int i = 0; i < 20 && instr_ready !== 1'b1; i++) @(negedge clk);
        check("ready_before_issue", instr_ready, 1);
        offer(op, rd, rs1, rs2, m, imm);
        e = sb[$];
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        seen = 0;
        for (int t = 1; t <= 6; t++) begin
            if (done === 1'b1) begin
                seen = 1;
                check("done_cycle", t, e.ill ? 2 : 3);
                e = sb.pop_front();
                check("illegal_pulse", illegal, e.ill);
                break;
            end
            check("ready_low_busy", instr_ready, 0);
            if (t == 2 && !e.ill) begin
                check("exec_alu_op", alu_op, e.op);
                check("exec_alu_r2", alu_r2, e.a);
                check("exec_alu_m", alu_m, e.m);
            end
            @(negedge clk);
        end
        check("done_seen", seen, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("ready_after_wb", instr_ready, 1);
        check("flags", flags, m_flags);
        check("retired", retired, m_ret);
        check_rf("rf_after_wb");
    endtask

    logic [15:0] p_w   [3];
    logic [15:0] p_imm [3];
    exp_t        pe;
    int          k, last, ndone;

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 16'h0;
        instr_imm = 16'h0;
        dbg_addr = 3'd0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_ready", instr_ready, 1);
        check("rst_done", done, 0);
        check("rst_flags", flags, 0);
        check("rst_retired", retired, 0);
        check("rst_alu_op", alu_op, 0);
        check_rf("rst_rf");
        rst = 1'b0;
        @(negedge clk);

        run(4'd9, 3'd1, 3'd0, 3'd0, 4'd0, 16'h0005);
        run(4'd9, 3'd2, 3'd0, 3'd0, 4'd0, 16'h0003);
        run(4'd0, 3'd3, 3'd1, 3'd2, 4'd0, 16'h0000);
        dbg_addr = 3'd3; #1;
        check("add_r3_const", dbg_data, 16'h0008);
        check("retired_3", retired, 16'd3);

        run(4'd1, 3'd4, 3'd2, 3'd1, 4'd0, 16'h0000);
        dbg_addr = 3'd4; #1;
        check("sub_r4_const", dbg_data, 16'hFFFE);
        check("sub_flags_const", flags, 4'b0111);
        run(4'd10, 3'd0, 3'd1, 3'd2, 4'd0, 16'h0000);
        check("cmp_flags_const", flags, 4'b0010);

        run(4'd7, 3'd5, 3'd1, 3'd0, 4'd4, 16'h0000);
        dbg_addr = 3'd5; #1;
        check("shl_r5_const", dbg_data, 16'h0050);
        run(4'd8, 3'd5, 3'd5, 3'd0, 4'd4, 16'h0000);
        dbg_addr = 3'd5; #1;
        check("ror_r5_const", dbg_data, 16'h0005);

        run(4'd12, 3'd1, 3'd2, 3'd3, 4'd0, 16'h1234);

        // Back-to-back offers with instr_valid held high.
        p_w[0] = {4'd9, 3'd0, 9'd0}; p_imm[0] = 16'h1111;
        p_w[1] = {4'd9, 3'd6, 9'd0}; p_imm[1] = 16'h2222;
        p_w[2] = {4'd9, 3'd7, 9'd0}; p_imm[2] = 16'h3333;
        k = 0; last = 0; ndone = 0;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            if (done === 1'b1) begin
                pe = sb.pop_front();
                check("pipe_illegal", illegal, pe.ill);
                ndone++;
            end
            check("pipe_ready", instr_ready, (k == 0) || (c - last >= 4));
            if (k < 3 && instr_ready === 1'b1) begin
                last = c;
                offer(4'd9, p_w[k][11:9], 3'd0, 3'd0, 4'd0, p_imm[k]);
                @(posedge clk);
                #1;
                k++;
                if (k == 3) instr_valid = 1'b0;
            end
        end
        check("pipe_accepts", k, 3);
        check("pipe_done_count", ndone, 3);
        check("pipe_retired", retired, m_ret);
        check_rf("pipe_rf");

        // Reset asserted while ADD r6 is in EXEC.
        @(negedge clk);
        offer(4'd0, 3'd6, 3'd1, 3'd2, 4'd0, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_clear();
        check("rst_mid_ready", instr_ready, 1);
        check("rst_mid_done", done, 0);
        check("rst_mid_flags", flags, 0);
        check("rst_mid_retired", retired, 0);
        check_rf("rst_mid_rf");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_no_done", done, 0);
        check_rf("rst_mid_rf_later");

        // Retired counter wrap.
        force dut.retired = 16'hFFFF;
        #1;
        release dut.retired;
        m_ret = 16'hFFFF;
        @(negedge clk);
        run(4'd9, 3'd1, 3'd0, 3'd0, 4'd0, 16'h00AA);
        check("retired_wrap_const", retired, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller that sequences the shared 16-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and decodes it.
- Reads operands from an internal 8x16 register file, drives the ALU operand/opcode/shift/immediate inputs from registers, then captures the ALU result and flags and writes them back.
- Sits between instruction issue logic and the combinational ALU; also keeps a flags register and a retired-instruction counter.

Parameters:
- WIDTH, 16, datapath width; must match the ALU size.
- NREG, 8, register file depth; index width is 3 bits.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept; high only in IDLE
- instr  in  16  [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [3:0] shift amount m (shift ops only)
- instr_imm  in  WIDTH  immediate, sampled with instr
- alu_r2  out  WIDTH  ALU operand A (registered)
- alu_r3  out  WIDTH  ALU operand B (registered)
- alu_m  out  4  ALU shift amount (registered)
- alu_op  out  4  ALU operation select (registered)
- alu_insta  out  WIDTH  ALU immediate (registered)
- alu_r1  in  WIDTH  ALU result
- alu_flags  in  4  ALU flags
- done  out  1  one-cycle pulse in WB
- illegal  out  1  one-cycle pulse in WB for a reserved op
- flags  out  4  last captured flags
- retired  out  16  count of completed instructions; wraps at 0xFFFF->0
- dbg_addr  in  3  debug register-file read index
- dbg_data  out  WIDTH  combinational read of rf[dbg_addr]

Behaviour:
- Reset (async, any state): state=IDLE; all rf entries, alu_* outputs, flags and retired = 0; done=illegal=0. Clearing happens mid-operation too, and the in-flight instruction is discarded with no write.
- Op encoding:
  - 0 ADD, 1 SUB, 2 MULT, 3 OR, 4 AND, 5 XOR, 6 SHR, 7 SHL, 8 ROR: ALU ops; write rd and update flags.
  - 9 LDI: immediate routed through the ALU; write rd, flags unchanged.
  - 10 CMP: update flags only, no rd write.
  - 11-15: reserved.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready, latch instr and instr_imm into the instruction register; go to READ.
- READ:
  - alu_r2<=rf[rs1], alu_r3<=rf[rs2], alu_op<=op, alu_insta<=imm.
  - alu_m<=instr[3:0] for ops 6-8, else 0.
  - Reserved op: alu_* unchanged; go straight to WB with an illegal marker.
- EXEC:
  - ALU settles; at the end of the cycle, capture alu_r1 and alu_flags into holding registers.
- WB:
  - Write rd from the holding register if the op writes.
  - Load flags if the op is ALU 0-8 or CMP.
  - done=1; illegal=1 for a reserved op.
  - retired+=1, including illegal ops.
  - Next state IDLE.
- Latency:
  - Handshake edge at cycle 0; done high in cycle 3; instr_ready high again in cycle 4.
  - Max throughput is one instruction per 4 cycles.
  - Reserved op: done and illegal in cycle 2.
- instr_valid while not ready: ignored; the offering side must hold it.
- rs1==rs2==rd: reads return the pre-write value; the write lands at the end of WB.
- dbg_data reflects a WB write from the cycle after WB.
- r0 is an ordinary writable register.
- Arithmetic width and truncation are defined by the ALU; the controller stores alu_r1 unmodified.
- alu_* hold their values outside READ.

Test Plan:
- Reset then LDI r1=0x0005, LDI r2=0x0003, ADD r3=r1+r2 -> dbg r3=0x0008; done exactly in cycle 3 after each accept; retired=3.
- SUB r4=r2-r1 with r1=5, r2=3 -> r4=0xFFFE; flags equal alu_flags captured in EXEC; then CMP r1,r2 -> flags update, all rf unchanged.
- SHL r5=r1, m=4 with r1=0x0005 -> alu_m=4 during EXEC, r5=0x0050; ROR r5, m=4 -> 0x0005.
- Op 0xC -> illegal and done pulse in cycle 2; no rf or flags change; retired increments.
- instr_valid held high continuously with 3 queued instructions -> accepts spaced exactly 4 cycles apart; instr_ready low in READ/EXEC/WB.
- Assert rst during EXEC of ADD r6 -> immediately IDLE, rf all 0, r6 never written, flags=0, retired=0; also cover retired wrap by preloading 0xFFFF (force) -> 0x0000.
